// File: rtl/fir_sym_mac.sv
// fir_sym_mac: symmetric FIR filter, NTAPS/2 unique coefficients,
// time-multiplexed onto a single MAC with valid/ready on both sides.
// Optional output saturation is enabled by defining FIR_SAT_EN;
// otherwise the scaled result wraps and sat_flag is tied low.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   x_in/_valid/_ready       input sample stream (signed)
//   coef_we/_addr/_wdata     coefficient write port, IDLE only
//   y_out/_valid/_ready      output sample stream (signed)
//   busy                     FSM not idle
//   sat_flag                 y_out was clamped (with y_out_valid)

module fir_sym_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NTAPS     = 32,
    parameter int FRAC_BITS = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [DATA_W-1:0]        x_in,
    input  logic                            x_in_valid,
    output logic                            x_in_ready,
    input  logic                            coef_we,
    input  logic [$clog2(NTAPS/2)-1:0]      coef_addr,
    input  logic signed [COEF_W-1:0]        coef_wdata,
    output logic signed [DATA_W-1:0]        y_out,
    output logic                            y_out_valid,
    input  logic                            y_out_ready,
    output logic                            busy,
    output logic                            sat_flag
);

    localparam int NU    = NTAPS / 2;
    localparam int AW    = $clog2(NU);
    localparam int TW    = $clog2(NTAPS);
    localparam int CW    = $clog2(NTAPS + 1);
    localparam int PW    = DATA_W + 1 + COEF_W;
    localparam int ACC_W = DATA_W + 1 + COEF_W + AW;

    localparam logic signed [ACC_W-1:0] RND =
        {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    if (NTAPS < 4 || (NTAPS % 2) != 0) begin : g_bad_ntaps
        $error("fir_sym_mac: NTAPS must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_W-1:0] r_tap  [NTAPS];
    logic signed [COEF_W-1:0] r_coef [NU];
    logic signed [ACC_W-1:0]  r_acc;
    logic [AW-1:0]            r_idx;
    logic [CW-1:0]            r_cnt;
    logic signed [DATA_W-1:0] r_y;
    logic                     r_vld;
    logic                     r_sat;

    logic                     w_last;
    logic                     w_full;
    logic                     w_cwe;
    logic [TW-1:0]            w_lo_idx;
    logic [TW-1:0]            w_hi_idx;
    logic signed [DATA_W-1:0] w_lo;
    logic signed [DATA_W-1:0] w_hi;
    logic signed [DATA_W:0]   w_sum;
    logic signed [PW-1:0]     w_sum_x;
    logic signed [PW-1:0]     w_coef_x;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic signed [ACC_W-1:0]  w_rnd;
    logic signed [DATA_W-1:0] w_y;
    logic                     w_sat;

    assign x_in_ready  = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign y_out       = r_y;
    assign y_out_valid = r_vld;
    assign sat_flag    = r_sat;

    assign w_last = (r_idx == AW'(NU - 1));
    assign w_full = (r_cnt == CW'(NTAPS));
    assign w_cwe  = coef_we && (r_state == S_IDLE) &&
                    ({1'b0, coef_addr} < (AW+1)'(NU));

    // Pair tap k with its mirror NTAPS-1-k so one multiply covers both.
    assign w_lo_idx  = {1'b0, r_idx};
    assign w_hi_idx  = TW'(NTAPS - 1) - w_lo_idx;
    assign w_lo      = r_tap[w_lo_idx];
    assign w_hi      = r_tap[w_hi_idx];
    assign w_sum     = {w_lo[DATA_W-1], w_lo} + {w_hi[DATA_W-1], w_hi};
    assign w_sum_x   = PW'(w_sum);
    assign w_coef_x  = PW'(r_coef[r_idx]);
    assign w_prod    = w_sum_x * w_coef_x;
    assign w_acc_nxt = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

    // Round half up, computed on the final sum so the output register
    // loads on the same edge as the last accumulation.
    assign w_rnd = w_acc_nxt + RND;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_r;

    assign w_r = w_rnd >>> FRAC_BITS;

    always_comb begin
        w_y   = w_r[DATA_W-1:0];
        w_sat = 1'b0;
        if (w_r > MAXV) begin
            w_y   = MAXV[DATA_W-1:0];
            w_sat = 1'b1;
        end else if (w_r < MINV) begin
            w_y   = MINV[DATA_W-1:0];
            w_sat = 1'b1;
        end
    end
`else
    assign w_y   = DATA_W'(w_rnd >>> FRAC_BITS);
    assign w_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (x_in_valid) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                // Until the delay line is primed the result is dropped.
                if (w_last) begin
                    w_state_nxt = w_full ? S_OUT : S_IDLE;
                end
            end
            S_OUT: begin
                if (y_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_tap[i] <= '0;
            end
            for (int i = 0; i < NU; i++) begin
                r_coef[i] <= '0;
            end
            r_acc <= '0;
            r_idx <= '0;
            r_cnt <= '0;
            r_y   <= '0;
            r_vld <= 1'b0;
            r_sat <= 1'b0;
        end else begin
            if (w_cwe) begin
                r_coef[coef_addr] <= coef_wdata;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (x_in_valid) begin
                        r_tap[0] <= x_in;
                        for (int i = 1; i < NTAPS; i++) begin
                            r_tap[i] <= r_tap[i-1];
                        end
                        if (!w_full) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + AW'(1);
                    if (w_last && w_full) begin
                        r_y   <= w_y;
                        r_sat <= w_sat;
                        r_vld <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (y_out_ready) begin
                        r_vld <= 1'b0;
                    end
                end
                default: begin
                    r_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sym_mac.sv
// tb_fir_sym_mac: scoreboard bench for fir_sym_mac (32 taps, Q15).
// Expected outputs are queued at issue time and popped on handshake.

module tb_fir_sym_mac;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] x_in;
    logic               x_in_valid;
    logic               x_in_ready;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [15:0] coef_wdata;
    logic signed [15:0] y_out;
    logic               y_out_valid;
    logic               y_out_ready;
    logic               busy;
    logic               sat_flag;

`ifdef FIR_SAT_EN
    localparam int SAT_Y = 32767;
    localparam int SAT_F = 1;
`else
    localparam int SAT_Y = -64;
    localparam int SAT_F = 0;
`endif

    typedef struct {
        logic signed [15:0] y;
        logic               s;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;

    fir_sym_mac #(
        .DATA_W    (16),
        .COEF_W    (16),
        .NTAPS     (32),
        .FRAC_BITS (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x_in        (x_in),
        .x_in_valid  (x_in_valid),
        .x_in_ready  (x_in_ready),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .y_out       (y_out),
        .y_out_valid (y_out_valid),
        .y_out_ready (y_out_ready),
        .busy        (busy),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void push(input int y, input int s);
        exp_t e;
        e.y = 16'(y);
        e.s = (s != 0);
        q.push_back(e);
    endfunction

    // Monitor: one pop per handshake.
    always @(negedge clk) begin
        if (!reset && y_out_valid && y_out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got y=%0d expected none",
                         y_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("y_out", y_out, e.y);
                check("sat_flag", sat_flag, e.s);
            end
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic write_coef(input int k, input int d);
        coef_we    = 1'b1;
        coef_addr  = 4'(k);
        coef_wdata = 16'(d);
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic send(input int x, output int acc_cyc);
        int n;
        n          = 0;
        x_in       = 16'(x);
        x_in_valid = 1'b1;
        @(negedge clk);
        while (!x_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!x_in_ready) begin
            n_chk++;
            $display("FAIL send_timeout: ready=0 expected 1");
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1 x_in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int vcyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!y_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!y_out_valid) begin
            n_chk++;
            $display("FAIL valid_timeout: valid=0 expected 1");
        end
        vcyc = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || y_out_valid) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("drain_queue", q.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_y"}, y_out, 0);
        check({tag, "_valid"}, y_out_valid, 0);
        check({tag, "_sat"}, sat_flag, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, x_in_ready, 1);
    endtask

    initial begin
        int a, a2, a3, a4, v, seen;
        reset       = 1'b1;
        x_in        = '0;
        x_in_valid  = 1'b0;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_wdata  = '0;
        y_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("rst");
        @(posedge clk);
        #1;

        // Impulse, plus a coefficient write during MAC that must be ignored
        write_coef(0, 1000);
        send(16384, a);
        for (int i = 0; i < 30; i++) send(0, a);
        push(500, 0);
        send(0, a);
        write_coef(0, 5000);
        wait_valid(v);
        check("latency", v - a, 17);
        @(posedge clk);
        #1 drain();

        // IDLE write landing on the same edge as the sample accept
        coef_we    = 1'b1;
        coef_addr  = 4'd0;
        coef_wdata = 16'sd5000;
        push(2500, 0);
        send(16384, a);
        coef_we = 1'b0;
        drain();

        // Saturation / wrap
        do_reset(2);
        for (int k = 0; k < 16; k++) write_coef(k, 32767);
        for (int i = 0; i < 31; i++) send(32767, a);
        push(SAT_Y, SAT_F);
        send(32767, a);
        drain();

        // Backpressure
        y_out_ready = 1'b0;
        push(SAT_Y, SAT_F);
        send(32767, a);
        wait_valid(v);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_y", y_out, SAT_Y);
            check("bp_valid", y_out_valid, 1);
            check("bp_ready", x_in_ready, 0);
        end
        @(posedge clk);
        #1 y_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_after_valid", y_out_valid, 0);
        check("bp_after_ready", x_in_ready, 1);
        check("bp_queue", q.size(), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of MAC drops the pending result
        send(32767, a);
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        @(posedge clk);
        #1 do_reset(1);
        @(negedge clk);
        check_idle("midrst");
        repeat (25) @(posedge clk);
        #1;

        // Priming then streaming
        write_coef(0, 1000);
        send(16384, a);
        send(-16384, a);
        for (int i = 0; i < 29; i++) send(0, a);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (y_out_valid) seen++;
        end
        check("prime_no_valid", seen, 0);
        @(posedge clk);
        #1;
        push(500, 0);
        send(0, a);
        push(-500, 0);
        send(0, a2);
        push(1000, 0);
        send(32767, a3);
        push(0, 0);
        send(0, a4);
        check("period_1", a2 - a, 18);
        check("period_2", a3 - a2, 18);
        check("period_3", a4 - a3, 18);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
